// File: rtl/alu_result_stage.sv
// Result FIFO between the ALU and the 32-bit bus. MUL/DIV results drain as LO then HI words.
// Optional zero/negative flags are built when ALU_RESULT_FLAGS_EN is defined.
module alu_result_stage #(
    parameter int unsigned DEPTH  = 2,
    parameter logic [4:0]  OP_MUL = 5'b01111,
    parameter logic [4:0]  OP_DIV = 5'b10000
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic [4:0]  ops,
    input  logic [63:0] zregin,
    input  logic        zin,
    output logic        zin_ready,
    output logic [31:0] bus_out,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [1:0]  bus_dest,
    output logic        ovf,
    output logic        z_flag,
    output logic        n_flag
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic {PH_LO, PH_HI} phase_e;

    logic [68:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    phase_e        r_phase;
    phase_e        w_phase_next;
    logic          r_ovf;

    logic [68:0]   w_head;
    logic          w_wide;
    logic          w_push;
    logic          w_pop;
    logic          w_hs;

    assign w_head    = r_mem[r_rd_ptr];
    assign w_wide    = (w_head[68:64] == OP_MUL) || (w_head[68:64] == OP_DIV);
    assign bus_valid = (r_count != '0);
    assign zin_ready = (r_count != CW'(DEPTH));
    assign w_push    = zin && zin_ready;
    assign w_hs      = bus_valid && bus_ready;
    assign ovf       = r_ovf;

    // Outputs are forced to zero while empty so stale storage never reaches the bus.
    always_comb begin
        w_phase_next = r_phase;
        w_pop        = 1'b0;
        bus_out      = '0;
        bus_dest     = 2'b00;
        unique case (r_phase)
            PH_LO: begin
                if (bus_valid) begin
                    bus_out  = w_head[31:0];
                    bus_dest = w_wide ? 2'b01 : 2'b00;
                end
                if (w_hs) begin
                    if (w_wide) begin
                        w_phase_next = PH_HI;
                    end else begin
                        w_pop = 1'b1;
                    end
                end
            end
            PH_HI: begin
                if (bus_valid) begin
                    bus_out  = w_head[63:32];
                    bus_dest = 2'b10;
                end
                if (w_hs) begin
                    w_pop        = 1'b1;
                    w_phase_next = PH_LO;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {ops, zregin};
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_phase  <= PH_LO;
            r_ovf    <= 1'b0;
        end else begin
            r_phase <= w_phase_next;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (zin && !zin_ready) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef ALU_RESULT_FLAGS_EN
    logic r_z;
    logic r_n;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_z <= 1'b0;
            r_n <= 1'b0;
        end else if (w_pop) begin
            if (w_wide) begin
                r_z <= (w_head[63:0] == 64'd0);
                r_n <= w_head[63];
            end else begin
                r_z <= (w_head[31:0] == 32'd0);
                r_n <= w_head[31];
            end
        end
    end

    assign z_flag = r_z;
    assign n_flag = r_n;
`else
    assign z_flag = 1'b0;
    assign n_flag = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: stimulus queues expected bus words, a negedge monitor
// pops and compares them on every handshake. Flag checks follow ALU_RESULT_FLAGS_EN.
module tb_alu_result_stage;
    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic [4:0]  ops = '0;
    logic [63:0] zregin = '0;
    logic        zin = 1'b0;
    logic        zin_ready;
    logic [31:0] bus_out;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic [1:0]  bus_dest;
    logic        ovf;
    logic        z_flag;
    logic        n_flag;

`ifdef ALU_RESULT_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    int n_pass  = 0;
    int n_total = 0;
    logic [33:0] exp_q[$];

    alu_result_stage dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .ops       (ops),
        .zregin    (zregin),
        .zin       (zin),
        .zin_ready (zin_ready),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_dest  (bus_dest),
        .ovf       (ovf),
        .z_flag    (z_flag),
        .n_flag    (n_flag)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Handshake happens at the next posedge; inputs are stable since 1 time unit after the last one.
    always @(negedge clock) begin
        if (clear_n && bus_valid && bus_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected word: got dest=%0h data=%0h expected none",
                         bus_dest, bus_out);
            end else begin
                check("bus word {dest,data}", {30'd0, bus_dest, bus_out},
                      {30'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        // Power-on reset
        step();
        check("reset bus_valid", bus_valid, 0);
        check("reset zin_ready", zin_ready, 1);
        check("reset ovf", ovf, 0);
        check("reset bus_out", bus_out, 0);
        check("reset bus_dest", bus_dest, 0);
        check("reset z_flag", z_flag, 0);
        check("reset n_flag", n_flag, 0);
        clear_n = 1'b1;
        step();

        // T2: single add
        bus_ready = 1'b1;
        zin = 1'b1; ops = 5'b00011; zregin = 64'h7;
        exp_q.push_back({2'b00, 32'h7});
        step();
        zin = 1'b0;
        check("t2 valid after 1 cycle", bus_valid, 1);
        step();
        check("t2 valid drops", bus_valid, 0);
        check("t2 z_flag", z_flag, 0);
        check("t2 n_flag", n_flag, 0);

        // T3: mul sends LO then HI
        zin = 1'b1; ops = 5'b01111; zregin = 64'h0000_0002_FFFF_FFFE;
        exp_q.push_back({2'b01, 32'hFFFF_FFFE});
        exp_q.push_back({2'b10, 32'h0000_0002});
        step();
        zin = 1'b0;
        step();
        check("t3 still valid for HI", bus_valid, 1);
        step();
        check("t3 valid drops", bus_valid, 0);
        check("t3 z_flag", z_flag, 0);
        check("t3 n_flag", n_flag, 0);

        // Narrow flags: only low word counts
        zin = 1'b1; ops = 5'b00011; zregin = 64'h0000_0001_0000_0000;
        exp_q.push_back({2'b00, 32'h0});
        step();
        zin = 1'b0;
        step();
        check("narrow zero z_flag", z_flag, FL);
        check("narrow zero n_flag", n_flag, 0);
        zin = 1'b1; ops = 5'b00011; zregin = 64'h0000_0001_8000_0000;
        exp_q.push_back({2'b00, 32'h8000_0000});
        step();
        zin = 1'b0;
        step();
        step();
        check("narrow neg z_flag", z_flag, 0);
        check("narrow neg n_flag held", n_flag, FL);

        // T4: stall until full, third push dropped
        bus_ready = 1'b0;
        zin = 1'b1; ops = 5'b00011; zregin = 64'hA1;
        exp_q.push_back({2'b00, 32'hA1});
        step();
        check("t4 ready after 1 push", zin_ready, 1);
        ops = 5'b00101; zregin = 64'hB2;
        exp_q.push_back({2'b00, 32'hB2});
        step();
        check("t4 ready after 2 push", zin_ready, 0);
        check("t4 ovf before drop", ovf, 0);
        ops = 5'b00011; zregin = 64'hC3;
        step();
        zin = 1'b0;
        check("t4 ovf set", ovf, 1);
        step();
        step();
        check("t4 bus_out held", bus_out, 32'hA1);
        check("t4 bus_dest held", bus_dest, 0);
        check("t4 ovf sticky", ovf, 1);
        bus_ready = 1'b1;
        step();
        step();
        check("t4 drained", bus_valid, 0);

        // T1: async reset mid-cycle with two entries queued
        bus_ready = 1'b0;
        zin = 1'b1; ops = 5'b00011; zregin = 64'h11;
        step();
        zregin = 64'h22;
        step();
        zin = 1'b0;
        check("t1 full before reset", zin_ready, 0);
        #2;
        clear_n = 1'b0;
        #1;
        check("t1 bus_valid in reset", bus_valid, 0);
        check("t1 zin_ready in reset", zin_ready, 1);
        check("t1 ovf in reset", ovf, 0);
        check("t1 bus_out in reset", bus_out, 0);
        step();
        clear_n = 1'b1;
        bus_ready = 1'b1;
        step();
        check("t1 empty after reset", bus_valid, 0);

        // T5: streaming with wrap, undecoded opcodes are single GPR words
        for (int i = 0; i < 8; i++) begin
            zin = 1'b1;
            ops = 5'(24 + i);
            zregin = {32'hFFFF_0000 + 32'(i), 32'h100 + 32'(i)};
            exp_q.push_back({2'b00, 32'h100 + 32'(i)});
            step();
            check("t5 ready", zin_ready, 1);
            check("t5 valid", bus_valid, 1);
            check("t5 ovf", ovf, 0);
        end
        zin = 1'b0;
        step();
        check("t5 drained", bus_valid, 0);
        check("t5 ovf end", ovf, 0);

        // T6: div, HI word held under stall
        zin = 1'b1; ops = 5'b10000; zregin = {32'd3, 32'd5};
        exp_q.push_back({2'b01, 32'd5});
        exp_q.push_back({2'b10, 32'd3});
        step();
        zin = 1'b0;
        step();
        bus_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t6 hi data held", bus_out, 32'd3);
            check("t6 hi dest held", bus_dest, 2'b10);
            step();
        end
        bus_ready = 1'b1;
        step();
        check("t6 drained", bus_valid, 0);

        // Wide flags use all 64 bits
        zin = 1'b1; ops = 5'b01111; zregin = 64'h8000_0000_0000_0000;
        exp_q.push_back({2'b01, 32'h0});
        exp_q.push_back({2'b10, 32'h8000_0000});
        step();
        zin = 1'b0;
        step();
        step();
        check("wide neg z_flag", z_flag, 0);
        check("wide neg n_flag", n_flag, FL);
        zin = 1'b1; ops = 5'b10000; zregin = 64'h0;
        exp_q.push_back({2'b01, 32'h0});
        exp_q.push_back({2'b10, 32'h0});
        step();
        zin = 1'b0;
        step();
        step();
        check("wide zero z_flag", z_flag, FL);
        check("wide zero n_flag", n_flag, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("scoreboard drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
